// File: rtl/rgb_frame_if.sv
// ============================================================================
// Module   : rgb_frame_if
// Brief    : Decoded-bit input and pixel valid/ready output bundle of rgb_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_frame_if #(
    parameter int IDX_W = 8
);
    logic             strobe;
    logic             sbit_value;
    logic             stream_reset;
    logic             pix_valid;
    logic             pix_ready;
    logic [23:0]      pix_grb;
    logic [IDX_W-1:0] pix_index;
    logic             frame_done;
    logic             short_pixel;
    logic             overflow;

    modport master (
        output strobe, sbit_value, stream_reset, pix_ready,
        input  pix_valid, pix_grb, pix_index, frame_done, short_pixel, overflow
    );

    modport slave (
        input  strobe, sbit_value, stream_reset, pix_ready,
        output pix_valid, pix_grb, pix_index, frame_done, short_pixel, overflow
    );
endinterface

`default_nettype wire

// File: rtl/rgb_frame_ctrl.sv
// ============================================================================
// Module   : rgb_frame_ctrl
// Brief    : Assembles GRB pixels from decoded bits, keeps the first NUM_PIXELS
//            of each frame and delivers them through a small valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_frame_ctrl #(
    parameter int NUM_PIXELS = 8,
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rgb_frame_if.slave bus
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(NUM_PIXELS + 1);
    localparam logic [c_CW-1:0] c_LAST_PIX = c_CW'(NUM_PIXELS - 1);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSEMBLE = 2'd1,
        S_DISCARD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [22:0]       r_sr;        // the oldest bit leaves straight into the pushed word
    logic [4:0]        r_bit_cnt;
    logic [c_CW-1:0]   r_pix_cnt;
    logic              r_frame_done;
    logic              r_short_pixel;
    logic              r_overflow;

    logic [IDX_W+23:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              r_pix_valid;
    logic [23:0]       r_pix_grb;
    logic [IDX_W-1:0]  r_pix_index;

    logic              w_bit;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic [IDX_W+23:0] w_push_word;
    logic [IDX_W+23:0] w_head;
    logic [c_AW:0]     w_rd_next;
    logic [c_AW:0]     w_wr_next;

    assign w_bit       = bus.strobe && !bus.stream_reset;
    assign w_push      = (r_state == S_ASSEMBLE) && w_bit && (r_bit_cnt == 5'd23);
    assign w_push_word = {IDX_W'(r_pix_cnt), r_sr, bus.sbit_value};
    assign w_pop       = r_pix_valid && bus.pix_ready;
    assign w_full      = (r_wr_ptr - r_rd_ptr) == c_DEPTH;
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_rd_next   = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
    assign w_wr_next   = r_wr_ptr + {{c_AW{1'b0}}, w_push_ok};
    // A word written this edge into an otherwise empty FIFO becomes the head directly.
    assign w_head      = (w_rd_next == r_wr_ptr) ? w_push_word : r_mem[w_rd_next[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_pix_cnt     <= '0;
            r_frame_done  <= 1'b0;
            r_short_pixel <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (bus.stream_reset && (r_state != S_IDLE)) begin
                r_state      <= S_IDLE;
                r_sr         <= '0;
                r_bit_cnt    <= '0;
                r_pix_cnt    <= '0;
                r_frame_done <= (r_pix_cnt != '0);
                if (r_bit_cnt != 5'd0) begin
                    r_short_pixel <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_bit) begin
                            r_state       <= S_ASSEMBLE;
                            r_sr          <= {r_sr[21:0], bus.sbit_value};
                            r_bit_cnt     <= 5'd1;
                            r_short_pixel <= 1'b0;
                            r_overflow    <= 1'b0;
                        end
                    end
                    S_ASSEMBLE: begin
                        if (w_bit) begin
                            r_sr <= {r_sr[21:0], bus.sbit_value};
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= 5'd0;
                                r_pix_cnt <= r_pix_cnt + 1'b1;
                                if (r_pix_cnt == c_LAST_PIX) begin
                                    r_state <= S_DISCARD;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_DISCARD: begin
                        r_state <= S_DISCARD;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pix_valid <= 1'b0;
            r_pix_grb   <= '0;
            r_pix_index <= '0;
        end else begin
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_pix_valid <= (w_wr_next != w_rd_next);
            if (w_wr_next != w_rd_next) begin
                r_pix_grb   <= w_head[23:0];
                r_pix_index <= w_head[IDX_W+23:24];
            end
        end
    end

    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_grb     = r_pix_grb;
    assign bus.pix_index   = r_pix_index;
    assign bus.frame_done  = r_frame_done;
    assign bus.short_pixel = r_short_pixel;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire
